// File: rtl/meter_cmd_sequencer_if.sv
// Command bus between the meter sequencer and the count datapath.
// Carries the LOAD/DEC handshake plus the count read-back.
interface meter_cmd_sequencer_if;
    logic        CMD_VALID;
    logic [1:0]  CMD_OP;
    logic [13:0] CMD_DATA;
    logic        CMD_READY;
    logic [13:0] COUNT;

    modport master (
        output CMD_VALID, CMD_OP, CMD_DATA,
        input  CMD_READY, COUNT
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_DATA,
        output CMD_READY, COUNT
    );
endinterface

// File: rtl/meter_cmd_sequencer.sv
// Parking-meter front end: debounce, 1 Hz tick, request arbitration,
// LOAD/DEC command issue, meter state and expiry display flashing.
module meter_cmd_sequencer #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned FLASH_HALF      = 25000000,
    parameter int unsigned MAX_COUNT       = 9999
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [3:0]                   BTN,
    input  logic [1:0]                   SWT,
    meter_cmd_sequencer_if.master        bus,
    output logic [1:0]                   STATE,
    output logic                         DISP_EN
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(CLK_HZ + 1);
    localparam int FL_W = $clog2(FLASH_HALF + 1);

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_EXP  = 2'b10
    } state_e;

    // Request bits: [3:0] buttons, [5:4] switches, [6] tick
    logic [5:0]            raw;
    logic [5:0]            lvl_q, lvl_d, rise;
    logic [5:0][DB_W-1:0]  db_q, db_d;
    logic [PS_W-1:0]       ps_q, ps_d;
    logic                  wrap;
    logic [6:0]            pend_q, pend_d, grant;
    logic                  valid_q, valid_d;
    logic [1:0]            op_q, op_d, op_n;
    logic [13:0]           data_q, data_d, data_n;
    logic [13:0]           amt;
    logic [14:0]           sum;
    logic                  is_btn, issue, xfer;
    state_e                state_q, state_d;
    logic [FL_W-1:0]       fl_q, fl_d;
    logic                  disp_q, disp_d;

    assign raw = {SWT, BTN};

    // Debounce: level flips after DEBOUNCE_CYCLES straight disagreements
    always_comb begin
        db_d  = '0;
        lvl_d = lvl_q;
        for (int i = 0; i < 6; i++) begin
            if (raw[i] != lvl_q[i]) begin
                if (db_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d[i] = raw[i];
                end else begin
                    db_d[i] = db_q[i] + DB_W'(1);
                end
            end
        end
        rise = lvl_d & ~lvl_q;
    end

    // Arbitrate pending requests into one command when the bus is free
    always_comb begin
        grant  = '0;
        amt    = '0;
        is_btn = 1'b0;
        issue  = 1'b0;
        op_n   = OP_IDLE;
        data_n = '0;
        if (!valid_q) begin
            priority case (1'b1)
                pend_q[3]: begin grant[3] = 1'b1; amt = 14'd500; is_btn = 1'b1; end
                pend_q[2]: begin grant[2] = 1'b1; amt = 14'd200; is_btn = 1'b1; end
                pend_q[1]: begin grant[1] = 1'b1; amt = 14'd150; is_btn = 1'b1; end
                pend_q[0]: begin grant[0] = 1'b1; amt = 14'd50;  is_btn = 1'b1; end
                pend_q[5]: begin
                    grant[5] = 1'b1;
                    issue    = 1'b1;
                    op_n     = OP_LOAD;
                    data_n   = 14'd205;
                end
                pend_q[4]: begin
                    grant[4] = 1'b1;
                    issue    = 1'b1;
                    op_n     = OP_LOAD;
                    data_n   = 14'd10;
                end
                pend_q[6]: begin
                    grant[6] = 1'b1;
                    if (bus.COUNT != '0) begin
                        issue = 1'b1;
                        op_n  = OP_DEC;
                    end
                end
                default: ;
            endcase
        end
        sum = {1'b0, bus.COUNT} + {1'b0, amt};
        if (is_btn) begin
            issue  = 1'b1;
            op_n   = OP_LOAD;
            data_n = (sum >= 15'(MAX_COUNT)) ? 14'(MAX_COUNT) : sum[13:0];
        end
    end

    // Prescaler, pending bits and command holding registers
    always_comb begin
        xfer    = valid_q & bus.CMD_READY;
        wrap    = (ps_q == PS_W'(CLK_HZ - 1));
        ps_d    = wrap ? '0 : ps_q + PS_W'(1);
        pend_d  = (pend_q & ~grant)
                | {wrap && (bus.COUNT != '0), rise};
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        if (xfer) begin
            valid_d = 1'b0;
            op_d    = OP_IDLE;
            data_d  = '0;
        end else if (issue) begin
            valid_d = 1'b1;
            op_d    = op_n;
            data_d  = data_n;
        end
    end

    // Front-end state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lvl_q   <= '0;
            db_q    <= '0;
            ps_q    <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            op_q    <= OP_IDLE;
            data_q  <= '0;
        end else begin
            lvl_q   <= lvl_d;
            db_q    <= db_d;
            ps_q    <= ps_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Meter state register with flash timer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            fl_q    <= '0;
            disp_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            fl_q    <= fl_d;
            disp_q  <= disp_d;
        end
    end

    // Next meter state, advanced only by accepted commands
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            unique case (state_q)
                S_IDLE, S_EXP: begin
                    if (op_q == OP_LOAD && data_q != '0) state_d = S_RUN;
                end
                S_RUN: begin
                    if (op_q == OP_DEC && bus.COUNT == 14'd1) state_d = S_EXP;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Display flashes only while staying in EXPIRED
    always_comb begin
        fl_d   = '0;
        disp_d = 1'b1;
        if (state_q == S_EXP && state_d == S_EXP) begin
            disp_d = disp_q;
            if (fl_q == FL_W'(FLASH_HALF - 1)) begin
                disp_d = ~disp_q;
            end else begin
                fl_d = fl_q + FL_W'(1);
            end
        end
    end

    // Drive outputs from registered state
    always_comb begin
        STATE         = state_q;
        DISP_EN       = disp_q;
        bus.CMD_VALID = valid_q;
        bus.CMD_OP    = op_q;
        bus.CMD_DATA  = data_q;
    end
endmodule

// File: tb/tb_meter_cmd_sequencer.sv
// Scoreboard bench for meter_cmd_sequencer with a small datapath model.
// Expected commands are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_meter_cmd_sequencer;
    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] BTN   = '0;
    logic [1:0] SWT   = '0;
    logic [1:0] STATE;
    logic       DISP_EN;

    meter_cmd_sequencer_if bus();

    meter_cmd_sequencer #(
        .CLK_HZ(20),
        .DEBOUNCE_CYCLES(4),
        .FLASH_HALF(5),
        .MAX_COUNT(9999)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .BTN(BTN),
        .SWT(SWT),
        .bus(bus.master),
        .STATE(STATE),
        .DISP_EN(DISP_EN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] data;
    } cmd_t;

    cmd_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        force_en = 1'b0;
    logic        dp_en = 1'b0;
    logic [13:0] force_val = '0;

    // Count datapath model: forced value or update on transfer
    always @(posedge CLK) begin
        if (force_en) begin
            bus.COUNT <= force_val;
        end else if (dp_en && bus.CMD_VALID && bus.CMD_READY) begin
            if (bus.CMD_OP == 2'b01) bus.COUNT <= bus.CMD_DATA;
            else if (bus.CMD_OP == 2'b10) bus.COUNT <= bus.COUNT - 14'd1;
        end
    end

    // Monitor: every valid cycle must match the head of the queue
    always @(negedge CLK) begin
        if (!RESET && bus.CMD_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmd: got op=%0d data=%0d, required none",
                         bus.CMD_OP, bus.CMD_DATA);
            end else if (bus.CMD_OP != exp_q[0].op ||
                         bus.CMD_DATA != exp_q[0].data) begin
                errors++;
                $display("FAIL cmd: got op=%0d data=%0d, required op=%0d data=%0d",
                         bus.CMD_OP, bus.CMD_DATA, exp_q[0].op, exp_q[0].data);
            end
            if (bus.CMD_READY && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_count(input logic [13:0] v);
        force_val = v;
        force_en  = 1'b1;
        tick(1);
        force_en  = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        BTN = '0;
        SWT = '0;
        bus.CMD_READY = 1'b0;
        dp_en = 1'b0;
        set_count(14'd0);
        tick(1);
        exp_q.delete();
        RESET = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input int data);
        exp_q.push_back({op, 14'(data)});
    endtask

    task automatic wait_size(input string name, input int sz, input int lim);
        int n = 0;
        while (exp_q.size() > sz && n < lim) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check(name, exp_q.size(), sz);
    endtask

    task automatic wait_drain(input string name, input int lim);
        wait_size(name, 0, lim);
        tick(1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.CMD_VALID && n < 20) begin
            tick(1);
            n++;
        end
        check(name, int'(bus.CMD_VALID), 1);
    endtask

    int tb_idx[5] = '{3, 0, 0, 2, 1};
    int tb_cnt[5] = '{9900, 9948, 9949, 100, 9999};
    int tb_exp[5] = '{9999, 9998, 9999, 300, 9999};

    initial begin
        bus.CMD_READY = 1'b0;
        tick(2);
        check("rst_valid", int'(bus.CMD_VALID), 0);
        check("rst_op", int'(bus.CMD_OP), 0);
        check("rst_data", int'(bus.CMD_DATA), 0);
        check("rst_state", int'(STATE), 0);
        check("rst_disp", int'(DISP_EN), 1);

        // Bouncing button yields a single LOAD 50
        do_reset();
        bus.CMD_READY = 1'b1;
        push(2'b01, 50);
        BTN[0] = 1'b1; tick(1);
        BTN[0] = 1'b0; tick(1);
        BTN[0] = 1'b1; tick(4);
        wait_drain("t1_drain", 20);
        check("t1_state", int'(STATE), 1);
        BTN[0] = 1'b0;
        tick(10);

        // Button adds with saturation at 9999
        for (int i = 0; i < 5; i++) begin
            do_reset();
            set_count(14'(tb_cnt[i]));
            bus.CMD_READY = 1'b1;
            push(2'b01, tb_exp[i]);
            BTN[tb_idx[i]] = 1'b1;
            wait_drain("t2_drain", 20);
            set_count(14'd0);
            check("t2_state", int'(STATE), 1);
        end

        // Simultaneous edges served in priority order with a bubble
        do_reset();
        bus.CMD_READY = 1'b1;
        push(2'b01, 150);
        push(2'b01, 205);
        BTN[1] = 1'b1;
        SWT[1] = 1'b1;
        wait_size("t3_first", 1, 20);
        @(negedge CLK); #1;
        check("t3_bubble", int'(bus.CMD_VALID), 0);
        @(negedge CLK); #1;
        check("t3_second_valid", int'(bus.CMD_VALID), 1);
        wait_drain("t3_drain", 10);

        // Held command stays stable across a tick; DEC follows
        do_reset();
        set_count(14'd100);
        dp_en = 1'b1;
        push(2'b01, 10);
        push(2'b10, 0);
        SWT[0] = 1'b1;
        wait_valid("t4_valid");
        tick(25);
        bus.CMD_READY = 1'b1;
        wait_drain("t4_drain", 10);
        check("t4_state", int'(STATE), 1);
        check("t4_count", int'(bus.COUNT), 9);

        // Expiry on last DEC, display flash, no more DECs
        do_reset();
        dp_en = 1'b1;
        bus.CMD_READY = 1'b1;
        push(2'b01, 10);
        push(2'b10, 0);
        SWT[0] = 1'b1;
        wait_size("t5_load", 1, 20);
        tick(2);
        set_count(14'd1);
        begin
            int n = 0;
            while (STATE != 2'b10 && n < 40) begin
                @(negedge CLK); #1;
                n++;
            end
        end
        check("t5_expired", int'(STATE), 2);
        check("t5_disp0", int'(DISP_EN), 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK); #1;
            check("t5_disp", int'(DISP_EN), (k >= 5 && k < 10) ? 0 : 1);
        end
        SWT[0] = 1'b0;
        tick(40);
        check("t5_still_expired", int'(STATE), 2);
        check("t5_count", int'(bus.COUNT), 0);
        check("t5_queue", exp_q.size(), 0);

        // Reset mid-handshake drops the command
        do_reset();
        bus.CMD_READY = 1'b1;
        push(2'b01, 10);
        SWT[0] = 1'b1;
        wait_drain("t6_load", 20);
        check("t6_run", int'(STATE), 1);
        bus.CMD_READY = 1'b0;
        push(2'b01, 205);
        SWT[1] = 1'b1;
        wait_valid("t6_valid");
        SWT = '0;
        tick(2);
        RESET = 1'b1;
        tick(1);
        check("t6_valid_drop", int'(bus.CMD_VALID), 0);
        check("t6_state", int'(STATE), 0);
        check("t6_disp", int'(DISP_EN), 1);
        exp_q.delete();
        RESET = 1'b0;
        bus.CMD_READY = 1'b1;
        tick(30);
        check("t6_no_reissue", int'(bus.CMD_VALID), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
